// File: rtl/stream_fifo.sv
// First-word fall-through stream FIFO with valid/ready handshakes on both sides,
// synchronous flush, occupancy count and registered almost-full/almost-empty flags.
module stream_fifo #(
  parameter int NBITS    = 16,
  parameter int DEPTH    = 3,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_val,
  output logic                       in_rdy,
  input  logic [NBITS-1:0]           in_msg,
  output logic                       out_val,
  input  logic                       out_rdy,
  output logic [NBITS-1:0]           out_msg,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full,
  output logic                       almost_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

  logic [NBITS-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          almost_full_reg;
  logic          almost_empty_reg;
  logic          push;
  logic          pop;

  // Handshake readiness depends only on registered occupancy, so neither side
  // sees a combinational path from the other.
  assign in_rdy  = (count_reg != CNT_FULL);
  assign out_val = (count_reg != '0);
  assign push    = in_val & in_rdy;
  assign pop     = out_val & out_rdy;

  assign out_msg      = out_val ? mem[rd_ptr_reg] : '0;
  assign count        = count_reg;
  assign almost_full  = almost_full_reg;
  assign almost_empty = almost_empty_reg;

  // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) begin
        wr_ptr_next = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_next = (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_next = count_reg + CW'(1);
        2'b01:   count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      almost_full_reg  <= (AF_LEVEL == 0);
      almost_empty_reg <= 1'b1;
    end else begin
      wr_ptr_reg       <= wr_ptr_next;
      rd_ptr_reg       <= rd_ptr_next;
      count_reg        <= count_next;
      // Flags derive from the next count so they update alongside count.
      almost_full_reg  <= (count_next >= AF_CNT);
      almost_empty_reg <= (count_next <= AE_CNT);
    end
  end

  // Storage is not reset; out_msg masks it whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) begin
      mem[wr_ptr_reg] <= in_msg;
    end
  end

endmodule

// File: doc/stream_fifo.md
STREAM_FIFO -- requirements
Module: stream_fifo

Interface
REQ-001 SHALL have parameter NBITS, default 16: payload width in bits, >= 1.
REQ-002 SHALL have parameter DEPTH, default 3: number of entries, any integer >= 2; power of two not required.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-1: almost-full threshold, 1..DEPTH.
REQ-004 SHALL have parameter AE_LEVEL, default 1: almost-empty threshold, 0..DEPTH-1.
REQ-005 SHALL have port clk, input, 1 bit: clock; all state updates on rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port flush, input, 1 bit: synchronous discard of all contents.
REQ-008 SHALL have port in_val, input, 1 bit: producer offers in_msg.
REQ-009 SHALL have port in_rdy, output, 1 bit: FIFO can accept an entry this cycle.
REQ-010 SHALL have port in_msg, input, NBITS bits: write payload.
REQ-011 SHALL have port out_val, output, 1 bit: out_msg holds the valid head entry.
REQ-012 SHALL have port out_rdy, input, 1 bit: consumer takes the head entry.
REQ-013 SHALL have port out_msg, output, NBITS bits: head-of-queue payload.
REQ-014 SHALL have port count, output, $clog2(DEPTH+1) bits: current occupancy.
REQ-015 SHALL have port almost_full, output, 1 bit: count >= AF_LEVEL.
REQ-016 SHALL have port almost_empty, output, 1 bit: count <= AE_LEVEL.

Function
REQ-017 SHALL define push = in_val & in_rdy and pop = out_val & out_rdy; transfers occur only on these.
REQ-018 SHALL drive in_rdy = (count != DEPTH), combinational from registered state only; no combinational in_rdy-to-out_rdy path.
REQ-019 SHALL drive out_val = (count != 0).
REQ-020 SHALL present the head entry on out_msg combinationally (first-word fall-through); out_msg SHALL be 0 when out_val = 0.
REQ-021 SHALL make pushed data visible at the head the cycle after push when empty (latency 1 cycle).
REQ-022 SHALL perform both transfers when push and pop coincide on a non-empty FIFO; count unchanged; order preserved.
REQ-023 SHALL ignore in_val when full (in_rdy = 0) and out_rdy when empty; no state change, no error.
REQ-024 SHALL increment count on push-only, decrement on pop-only, else hold.
REQ-025 SHALL wrap read and write pointers from DEPTH-1 to 0 for any DEPTH, not modulo 2^n.
REQ-026 SHALL preserve strict FIFO order across any number of wraps.
REQ-027 SHALL make flush zero the pointers and count next cycle; flush SHALL override a push or pop in the same cycle, and the concurrent push is dropped.
REQ-028 SHALL register almost_full and almost_empty as functions of the registered count, so both change in the same cycle as count.

Reset
REQ-029 SHALL clear on rst: count = 0, pointers = 0, in_rdy = 1, out_val = 0, out_msg = 0, almost_full = (AF_LEVEL == 0 ? 1 : 0), almost_empty = 1.
REQ-030 SHALL give rst priority over flush, push and pop; a mid-operation reset discards all contents.
REQ-031 SHALL leave storage array contents unreset; they are never observable because of REQ-020.

Verification (NBITS=16, DEPTH=3, AF_LEVEL=2, AE_LEVEL=1)
REQ-032 SHALL check: push 0x0001, 0x0002, 0x0003 with out_rdy=0 -> count 1,2,3; in_rdy=0 after third; almost_full=1 from count 2; a fourth push of 0x0004 is ignored.
REQ-033 SHALL check: from full, pop three times -> out_msg 0x0001, 0x0002, 0x0003 in order; then out_val=0, out_msg=0, almost_empty=1.
REQ-034 SHALL check: with count=1, in_val=1 and out_rdy=1 for 10 cycles with an incrementing payload -> count stays 1 and outputs appear in order across pointer wraps (DEPTH=3 is non-power-of-two).
REQ-035 SHALL check: with count=2, assert flush together with in_val=1 and out_rdy=1 -> next cycle count=0, out_val=0, and the pushed word is absent.
REQ-036 SHALL check: with count=3, assert rst together with flush and in_val -> next cycle count=0, in_rdy=1, out_val=0; pushing 0x00AA afterwards yields out_msg=0x00AA one cycle later.
REQ-037 SHALL check: random in_val/out_rdy for 10k cycles against a reference queue model -> no data loss, no reorder, count always in 0..3.
